fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage downstream of the 8-bit x 16 synchronous FIFO. It drains bytes from the FIFO read port and serializes each one as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits. It is the only consumer of the FIFO read port. It accounts for the FIFO's registered read data, which is valid one clock after the read enable is sampled.

## Interface
- CLKS_PER_BIT, default 16: clocks per serial bit; legal range 2..65535.
- PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits the start of a new frame.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO registered read data.
- fifo_re  out  1  FIFO read enable.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, next state is FETCH; otherwise stay in IDLE.
- FETCH: lasts exactly 1 cycle. fifo_re=1 only in this state, decoded directly from state. Next state is LATCH.
- LATCH: lasts 1 cycle. fifo_data is valid; capture it into the 8-bit shift register. Compute parity as the XOR of the 8 captured bits. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift_reg[0]. Every CLKS_PER_BIT cycles, shift right and increment bit_cnt, which is 3 bits wide.
  - After bit 7 completes, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, so that the total count of ones across data plus parity is even. Then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the final cycle of STOP.
  - On exit, go to FETCH if enable=1 and fifo_empty=0, else IDLE.
- baud_cnt counts from 0 to CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT). It clears on every state entry.
- enable is sampled only in IDLE and on exit from STOP. Deasserting enable mid-frame does not truncate the frame.
- fifo_empty is sampled only at the same two decision points. The FIFO has no other reader, so a non-empty FIFO cannot become empty before the read in FETCH.
- tx, fifo_re and frame_done are glitch-free:
  - tx is registered.
  - fifo_re and frame_done are decoded from registered state and counters.

## Timing
- Reset values: state=IDLE, tx=1, busy=0, fifo_re=0, frame_done=0, and all counters and the shift register at 0.
- Reset asserted mid-frame: at the next edge tx returns to 1 and state returns to IDLE. No FIFO read occurs in that cycle and no frame_done pulse is produced.
- Latency: the start bit begins 2 cycles after IDLE exits (the FETCH and LATCH cycles).
- Frame length from FETCH entry to frame_done: 2 + (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: STOP is followed directly by FETCH. The line stays high for 2 extra cycles between frames, which is legal extra stop time.
- fifo_re is never asserted while fifo_empty=1, and never asserted for 2 consecutive cycles.
- busy rises in the cycle after IDLE exits and falls in the cycle after frame_done.

## Test plan
1. Basic frame. CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1. Write 0xA5 to the FIFO, then enable=1.
   - Required: exactly one fifo_re pulse.
   - tx sequence, each value held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
   - frame_done pulses 42 cycles after FETCH entry.
   - FIFO ends empty; busy returns to 0.
2. Parity. PARITY_EN=1. Send 0x07 (three ones), then 0x03 (two ones).
   - Required: parity bit = 1 for 0x07, then 0 for 0x03.
   - Each frame is 46 cycles long.
3. Burst drain. Write 4 bytes 0x11, 0x22, 0x33, 0x44, with enable held at 1.
   - Required: 4 frames transmitted in order with exactly 2 high cycles between stop and the next start.
   - 4 fifo_re pulses, 4 frame_done pulses, and fifo_empty=1 at the end.
4. Enable and empty gating.
   - enable=0 with a non-empty FIFO: fifo_re stays 0 and tx stays 1 for 100 cycles.
   - Dropping enable during the DATA state: the current frame completes, then the block returns to IDLE.
   - enable=1 with an empty FIFO: no fifo_re pulse.
5. Reset mid-frame. Assert rst during data bit 3.
   - Required: at the next edge tx=1, busy=0, fifo_re=0.
   - After release, a new byte transmits correctly.
6. Two stop bits. STOP_BITS=2, CLKS_PER_BIT=4. Send 0xFF.
   - Required: stop high time is 8 cycles.
   - frame_done pulses 46 cycles after FETCH entry.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmit stage: drains bytes from an 8x16 synchronous FIFO and sends each
// as start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic              parity;
    logic              parity_next;
    logic              tx_next;
    logic              baud_done;
    logic              start_ok;

    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign start_ok   = enable && !fifo_empty;
    assign fifo_re    = (state == FETCH);
    assign busy       = (state != IDLE);
    // bit_cnt doubles as the stop-bit counter while in STOP
    assign frame_done = (state == STOP) && baud_done && (bit_cnt == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity    <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            parity    <= parity_next;
            tx        <= tx_next;
        end
    end

    // Next state and counters; baud_cnt defaults to 0 so it clears on every state entry
    always_comb begin
        state_next  = state;
        baud_next   = '0;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity;
        tx_next     = 1'b1;

        unique case (state)
            IDLE: begin
                if (start_ok) state_next = FETCH;
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                shift_next  = fifo_data;
                parity_next = ^fifo_data;
                bit_next    = '0;
                state_next  = START;
            end
            START: begin
                if (baud_done) state_next = DATA;
                else           baud_next  = baud_cnt + BAUD_W'(1);
            end
            DATA: begin
                if (baud_done) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baud_done) state_next = STOP;
                else           baud_next  = baud_cnt + BAUD_W'(1);
            end
            STOP: begin
                if (baud_done) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = start_ok ? FETCH : IDLE;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // tx is registered from the upcoming state so it lines up with state
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four configurations fed by a FIFO model, a per-instance
// frame monitor built from the UART framing rules, directed vectors and random traffic.
module tb_fifo_uart_tx;
    localparam int N = 4;
    localparam int CPB [N] = '{4, 4, 4, 3};
    localparam int PAR [N] = '{0, 1, 0, 1};
    localparam int STP [N] = '{1, 1, 2, 2};

    logic       clk = 1'b0;
    logic       rst   [N];
    logic       en    [N];
    logic       empty [N];
    logic       re    [N];
    logic       tx    [N];
    logic       busy  [N];
    logic       done  [N];
    logic [7:0] fdata [N];

    logic [7:0] mem [N][16];
    int         wp  [N] = '{default: 0};
    int         rp  [N] = '{default: 0};
    int         mrp [N] = '{default: 0};

    int   checks = 0;
    int   errors = 0;
    logic cap [128];
    int   cap_len;

    typedef struct {
        int         inst;
        logic [7:0] data;
        bit         chk_par;
        logic       exp_par;
        int         exp_len;
        int         exp_stop;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign empty[g] = (wp[g] == rp[g]);
        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB[g]),
            .PARITY_EN   (PAR[g]),
            .STOP_BITS   (STP[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .enable    (en[g]),
            .fifo_empty(empty[g]),
            .fifo_data (fdata[g]),
            .fifo_re   (re[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .frame_done(done[g])
        );
    end

    // FIFO read port: data registered one clock after the sampled read enable
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (re[i] && (wp[i] != rp[i])) begin
                fdata[i] <= mem[i][rp[i] % 16];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wp[i] % 16] = b;
        wp[i]++;
    endtask

    function automatic int frame_len(input int i);
        return 2 + (9 + PAR[i] + STP[i]) * CPB[i];
    endfunction

    // Expected line level k cycles after the read enable, from the framing rules
    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        int seg;
        if (k < 2) return 1'b1;
        seg = (k - 2) / CPB[i];
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        if (seg == 9 && PAR[i] != 0) return ^b;
        return 1'b1;
    endfunction

    task automatic monitor(input int i);
        logic [7:0] b;
        int         len, done_at, extra, bad, bsy_bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst[i]) continue;
            if (re[i]) begin
                check($sformatf("re_while_empty%0d", i), int'(empty[i]), 0);
                b       = mem[i][mrp[i] % 16];
                mrp[i]++;
                len     = frame_len(i);
                done_at = -1;
                extra   = 0;
                bad     = -1;
                bsy_bad = 0;
                aborted = 1'b0;
                for (int k = 0; k < len; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst[i]) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k > 0 && re[i]) extra++;
                    if (!busy[i]) bsy_bad++;
                    if (done[i] && done_at < 0) done_at = k;
                    if (tx[i] !== exp_bit(i, b, k) && bad < 0) bad = k;
                end
                if (!aborted) begin
                    check($sformatf("tx_first_bad_cycle%0d_byte%02h", i, b), bad, -1);
                    check($sformatf("frame_done_cycle%0d", i), done_at, len - 1);
                    check($sformatf("extra_re%0d", i), extra, 0);
                    check($sformatf("busy_low_in_frame%0d", i), bsy_bad, 0);
                end
            end else begin
                check($sformatf("stray_frame_done%0d", i), int'(done[i]), 0);
            end
        end
    endtask

    task automatic wait_for(input string name, input int i, input bit on_done, input int lim);
        bit hit = 1'b0;
        for (int k = 0; k < lim && !hit; k++) begin
            @(negedge clk);
            hit = on_done ? done[i] : re[i];
        end
        check(name, int'(hit), 1);
    endtask

    task automatic capture(input string name, input int i);
        cap_len = 0;
        wait_for({name, "_fetch"}, i, 1'b0, 40);
        for (int k = 0; k < 128; k++) begin
            cap[k] = tx[i];
            if (done[i]) begin
                cap_len = k + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int i, input logic [7:0] data,
                               input int exp_len);
        logic [7:0] got;
        int         c;
        c = CPB[i];
        capture(name, i);
        check({name, "_len"}, cap_len, exp_len);
        for (int j = 0; j < 8; j++) got[j] = cap[2 + (1 + j) * c + c / 2];
        check({name, "_data"}, int'(got), int'(data));
    endtask

    initial begin
        int i, c, ones, st, bad, cnt_re, cnt_done, gap, ngap;
        bit counting, all_idle;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 42, 4};
        vecs[1] = '{1, 8'h07, 1'b1, 1'b1, 46, 4};
        vecs[2] = '{1, 8'h03, 1'b1, 1'b0, 46, 4};
        vecs[3] = '{2, 8'hFF, 1'b0, 1'b0, 46, 8};
        vecs[4] = '{3, 8'h5C, 1'b1, 1'b0, 38, 6};

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            en[k]  = 1'b0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_tx%0d", k), int'(tx[k]), 1);
            check($sformatf("reset_busy%0d", k), int'(busy[k]), 0);
            check($sformatf("reset_re%0d", k), int'(re[k]), 0);
            check($sformatf("reset_done%0d", k), int'(done[k]), 0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // Directed single frames
        for (int v = 0; v < 5; v++) begin
            i = vecs[v].inst;
            c = CPB[i];
            push(i, vecs[v].data);
            en[i] = 1'b1;
            check_frame($sformatf("vec%0d", v), i, vecs[v].data, vecs[v].exp_len);
            if (vecs[v].chk_par)
                check($sformatf("vec%0d_parity", v), int'(cap[2 + 9 * c + c / 2]),
                      int'(vecs[v].exp_par));
            st   = 2 + (9 + PAR[i]) * c;
            ones = 0;
            for (int k = st; k < cap_len; k++) if (cap[k]) ones++;
            check($sformatf("vec%0d_stop_high", v), ones, vecs[v].exp_stop);
            en[i] = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_busy_after", v), int'(busy[i]), 0);
            check($sformatf("vec%0d_empty_after", v), int'(empty[i]), 1);
        end

        // Burst drain: four back-to-back frames with two high cycles between them
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
        en[0]    = 1'b1;
        cnt_re   = 0;
        cnt_done = 0;
        counting = 1'b0;
        gap      = 0;
        ngap     = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (re[0]) cnt_re++;
            if (counting) begin
                if (tx[0]) gap++;
                else begin
                    check($sformatf("burst_gap%0d", ngap), gap, 2);
                    ngap++;
                    counting = 1'b0;
                end
            end
            if (done[0]) begin
                cnt_done++;
                counting = 1'b1;
                gap      = 0;
            end
        end
        check("burst_re_pulses", cnt_re, 4);
        check("burst_done_pulses", cnt_done, 4);
        check("burst_gaps_seen", ngap, 3);
        check("burst_empty_end", int'(empty[0]), 1);
        en[0] = 1'b0;

        // Enable gating with a non-empty FIFO
        @(negedge clk);
        push(0, 8'h5A);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (re[0] || !tx[0]) bad++;
        end
        check("gate_disabled_activity", bad, 0);
        en[0] = 1'b1;
        wait_for("gate_fetch", 0, 1'b0, 10);
        repeat (12) @(negedge clk);
        en[0] = 1'b0;
        wait_for("gate_frame_done", 0, 1'b1, 60);
        @(negedge clk);
        check("gate_busy_after", int'(busy[0]), 0);
        // Enable with an empty FIFO
        en[0] = 1'b1;
        bad   = 0;
        repeat (30) begin
            @(negedge clk);
            if (re[0] || busy[0]) bad++;
        end
        check("empty_fifo_activity", bad, 0);

        // Reset during data bit 3, then a clean frame
        push(0, 8'h96);
        wait_for("rst_fetch", 0, 1'b0, 10);
        repeat (2 + 4 * 4 + 1) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", int'(tx[0]), 1);
        check("rst_mid_busy", int'(busy[0]), 0);
        check("rst_mid_re", int'(re[0]), 0);
        check("rst_mid_done", int'(done[0]), 0);
        @(negedge clk);
        rst[0] = 1'b0;
        push(0, 8'hC3);
        check_frame("after_rst", 0, 8'hC3, 42);
        en[0] = 1'b0;

        // Random traffic; the monitors check every frame that starts
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            i = int'($urandom_range(N - 1));
            if ($urandom_range(9) == 0 && (wp[i] - rp[i]) < 15) push(i, 8'($urandom));
            if ($urandom_range(24) == 0) begin
                i     = int'($urandom_range(N - 1));
                en[i] = ~en[i];
            end
        end
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        all_idle = 1'b0;
        for (int k = 0; k < 1500 && !all_idle; k++) begin
            @(negedge clk);
            all_idle = 1'b1;
            for (int j = 0; j < N; j++) if (!empty[j] || busy[j]) all_idle = 1'b0;
        end
        check("random_drain_idle", int'(all_idle), 1);
        for (int k = 0; k < N; k++) begin
            check($sformatf("random_frames_sent%0d", k), mrp[k], wp[k]);
            en[k] = 1'b0;
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
